// File: rtl/tinv_bus_arbiter.sv
// tinv_bus_arbiter: round-robin owner selection for a shared tri-state bus with break-before-make dead time.
module tinv_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int DEAD_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                    CLK,
  input  logic                    RN,
  input  logic [NREQ-1:0]         REQ,
  output logic [NREQ-1:0]         EN,
  output logic [NREQ-1:0]         EN_BAR,
  output logic [$clog2(NREQ)-1:0] OWNER,
  output logic                    BUSY,
  output logic                    GUARD
);
  localparam int OW = $clog2(NREQ);
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
  typedef enum logic [1:0] {IDLE, GRANT, DEAD} state_t;
  state_t state, state_nxt;
  logic [OW-1:0] ptr, ptr_nxt, owner_nxt, win, owner_inc;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [DW-1:0] dead_cnt, dead_nxt;
  logic [NREQ-1:0] en_nxt;
  logic hit, release_now;
  int j;
  always_comb begin
    hit = 1'b0;
    win = '0;
    j = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!hit && REQ[OW'(j)]) begin
        hit = 1'b1;
        win = OW'(j);
      end
    end
  end
  assign owner_inc = OWNER == OW'(NREQ - 1) ? '0 : OWNER + 1'b1;
  assign release_now = !REQ[OWNER] || (MAX_HOLD != 0 && hold_cnt == HOLD_LAST);
  always_comb begin
    state_nxt = state;
    ptr_nxt = ptr;
    owner_nxt = OWNER;
    hold_nxt = hold_cnt;
    dead_nxt = dead_cnt;
    en_nxt = EN;
    if (state == IDLE || (state == DEAD && dead_cnt == '0)) begin
      state_nxt = hit ? GRANT : IDLE;
      owner_nxt = hit ? win : OWNER;
      en_nxt = hit ? NREQ'(1) << win : '0;
      hold_nxt = '0;
    end else if (state == DEAD) begin
      dead_nxt = dead_cnt - 1'b1;
    end else if (release_now) begin
      // the pointer moves past the releasing owner so a preempted requester queues behind the rest
      state_nxt = DEAD;
      en_nxt = '0;
      dead_nxt = DW'(DEAD_CYC - 1);
      ptr_nxt = owner_inc;
    end else begin
      hold_nxt = &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
    end
  end
  // EN and EN_BAR are separate flops so both tinv inputs switch cleanly on the same edge
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
      ptr <= '0;
      OWNER <= '0;
      hold_cnt <= '0;
      dead_cnt <= '0;
      EN <= '0;
      EN_BAR <= '1;
      BUSY <= 1'b0;
      GUARD <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      OWNER <= owner_nxt;
      hold_cnt <= hold_nxt;
      dead_cnt <= dead_nxt;
      EN <= en_nxt;
      EN_BAR <= ~en_nxt;
      BUSY <= state_nxt == GRANT;
      GUARD <= state_nxt == DEAD;
    end
  end
endmodule

// File: tb/tb_tinv_bus_arbiter.sv
// tb_tinv_bus_arbiter: directed and randomized checks of the bus arbiter against a behavioural model.
module tb_tinv_bus_arbiter;
  localparam int N = 4, DC = 1, MH = 16;
  localparam int N2 = 3, DC2 = 2, MH2 = 0;
  localparam int STARVE = (N - 1) * (MH + DC) + DC;
  logic clk = 1'b0, rn = 1'b0;
  logic [N-1:0] req = '0, en, en_bar, exp_en, exp_bar, prev = '0;
  logic [1:0] owner;
  logic busy, guard;
  logic [N2-1:0] req2 = '0, en2, en_bar2, exp_bar2, prev2 = '0;
  logic [1:0] owner2;
  logic busy2, guard2;
  int checks = 0, errors = 0;
  int m_own = -1, m_held = 0, m_gap = DC + 1, m_ptr = 0;
  int wait_c [N];
  int run = 0, run2 = 0;
  bit seen = 1'b0, seen2 = 1'b0;
  always #5 clk = ~clk;
  tinv_bus_arbiter #(.NREQ(N), .DEAD_CYC(DC), .MAX_HOLD(MH)) dut (
    .CLK(clk), .RN(rn), .REQ(req), .EN(en), .EN_BAR(en_bar),
    .OWNER(owner), .BUSY(busy), .GUARD(guard)
  );
  tinv_bus_arbiter #(.NREQ(N2), .DEAD_CYC(DC2), .MAX_HOLD(MH2)) dut2 (
    .CLK(clk), .RN(rn), .REQ(req2), .EN(en2), .EN_BAR(en_bar2),
    .OWNER(owner2), .BUSY(busy2), .GUARD(guard2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction
  // gap counts all-off cycles since the last release; idle is simply a gap beyond the dead time
  always @(posedge clk or negedge rn) begin
    if (!rn) begin
      m_own = -1; m_held = 0; m_gap = DC + 1; m_ptr = 0;
    end else if (m_own >= 0) begin
      if (!req[m_own] || (MH != 0 && m_held == MH)) begin
        m_ptr = (m_own + 1) % N; m_own = -1; m_gap = 1;
      end else m_held++;
    end else if (m_gap < DC) m_gap++;
    else if (req != 0) begin
      m_own = pick(req, m_ptr); m_held = 1;
    end else m_gap = DC + 1;
  end
  always @(posedge clk) begin
    #1;
    exp_en = m_own >= 0 ? N'(1) << m_own : '0;
    exp_bar = ~exp_en;
    chk("en", en, exp_en);
    chk("en_bar", en_bar, exp_bar);
    chk("busy", busy, m_own >= 0);
    chk("guard", guard, m_own < 0 && m_gap <= DC);
    if (m_own >= 0) chk("owner", owner, m_own);
    chk("onehot", $countones(en) <= 1, 1);
    if (!rn) begin seen = 1'b0; seen2 = 1'b0; end
    if (en == 0) run++;
    else begin
      if (seen && en != prev) chk("gap", run >= DC, 1);
      run = 0; seen = 1'b1;
    end
    prev = en;
    for (int i = 0; i < N; i++) begin
      wait_c[i] = (rn && req[i] && !en[i]) ? wait_c[i] + 1 : 0;
      chk("starve", wait_c[i] <= STARVE, 1);
    end
    exp_bar2 = ~en2;
    chk("onehot2", $countones(en2) <= 1, 1);
    chk("en_bar2", en_bar2, exp_bar2);
    chk("busy2", busy2, en2 != 0);
    chk("busy_guard2", busy2 && guard2, 0);
    if (en2 == 0) run2++;
    else begin
      if (seen2 && en2 != prev2) chk("gap2", run2 >= DC2, 1);
      run2 = 0; seen2 = 1'b1;
    end
    prev2 = en2;
  end
  task automatic step();
    @(posedge clk);
    #3;
  endtask
  task automatic grant(input int o, input string tag);
    for (int c = 0; c < MH; c++) begin
      step();
      chk({tag, "_en"}, en, N'(1) << o);
    end
    step();
    chk({tag, "_gap_en"}, en, 0);
    chk({tag, "_gap_guard"}, guard, 1);
  endtask
  initial forever begin
    @(posedge clk);
    #3;
    if ($urandom_range(0, 3) == 0) req2 = N2'($urandom_range(0, 7));
  end
  initial begin
    repeat (2) @(posedge clk);
    #3;
    rn = 1'b1;
    chk("rst_en", en, 0);
    chk("rst_en_bar", en_bar, 4'hF);
    chk("rst_busy", busy, 0);
    chk("rst_guard", guard, 0);
    chk("rst_owner", owner, 0);
    req = 4'b0010;
    step();
    chk("t1_en", en, 4'b0010);
    chk("t1_en_bar", en_bar, 4'b1101);
    chk("t1_busy", busy, 1);
    chk("t1_owner", owner, 1);
    req = 4'b0000;
    step();
    chk("t2_en", en, 0);
    chk("t2_guard", guard, 1);
    chk("t2_busy", busy, 0);
    step();
    chk("t2_idle_guard", guard, 0);
    chk("t2_idle_busy", busy, 0);
    rn = 1'b0;
    #2;
    rn = 1'b1;
    req = 4'b1111;
    grant(0, "t3g0");
    grant(1, "t3g1");
    grant(2, "t3g2");
    req = 4'b1001;
    grant(3, "t4g3");
    grant(0, "t4g0");
    step();
    chk("t5_pre_en", en, 4'b1000);
    step();
    #4;
    rn = 1'b0;
    #1;
    chk("t5_async_en", en, 0);
    chk("t5_async_en_bar", en_bar, 4'hF);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_guard", guard, 0);
    @(posedge clk);
    #3;
    rn = 1'b1;
    req = 4'b0100;
    step();
    chk("t5_en", en, 4'b0100);
    chk("t5_owner", owner, 2);
    repeat (10000) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) req[i] = $urandom_range(0, 7) == 0;
        else if (m_own == i) req[i] = $urandom_range(0, 23) != 0;
        else req[i] = $urandom_range(0, 63) != 0;
      end
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
